// File: rtl/blur_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// blur_mem_arbiter_if
//
// Purpose: bundles the two requester handshakes (Gaussian writer, detect
// reader) and the registered blur-memory row command into one interface.
//
// Handshake: a requester raises *_req with a stable *_row and holds both until
// it sees *_ack high in the same cycle (the ack is combinational). The
// transfer happens on the rising clock edge at the end of that cycle. The
// requester may present its next request in the following cycle. An ack
// without a held req never occurs.
//
// Signals:
//   gauss_req/gauss_row/gauss_ack  Gaussian row-write request and grant
//   det_req/det_row/det_ack        detect row-read request and grant
//   mem_en/mem_we/mem_addr         registered memory row command
//
// Modports:
//   master  requester/memory side (drives reqs, observes acks and command)
//   slave   arbiter side (observes reqs, drives acks and command)
// -----------------------------------------------------------------------------
interface blur_mem_arbiter_if #(
    parameter int AW = 9
);
    logic          gauss_req;
    logic [AW-1:0] gauss_row;
    logic          gauss_ack;
    logic          det_req;
    logic [AW-1:0] det_row;
    logic          det_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;

    modport master (
        output gauss_req,
        output gauss_row,
        output det_req,
        output det_row,
        input  gauss_ack,
        input  det_ack,
        input  mem_en,
        input  mem_we,
        input  mem_addr
    );

    modport slave (
        input  gauss_req,
        input  gauss_row,
        input  det_req,
        input  det_row,
        output gauss_ack,
        output det_ack,
        output mem_en,
        output mem_we,
        output mem_addr
    );
endinterface

// File: rtl/blur_mem_arbiter.sv
// -----------------------------------------------------------------------------
// blur_mem_arbiter
//
// Purpose: arbitrates a single-port blur row memory between the Gaussian
// stage (writes rows in order) and the detect stage (reads rows). A read of
// row r is only allowed once the writer is LAG rows ahead of it, clipped at
// the bottom of the frame. When both sides are eligible, a round-robin
// pointer alternates grants. Each grant issues one registered memory command
// one cycle later.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle pulse starting a frame (honoured in IDLE/DONE only)
//   bus          blur_mem_arbiter_if.slave: requests, acks, memory command
//   wr_count     rows written this frame (saturates at ROWS)
//   rd_count     rows read this frame (saturates at ROWS)
//   busy         high in RUN and FLUSH
//   done         high in DONE
//   err          sticky: a granted Gaussian write was out of order
//   state_dbg    current FSM state encoding (IDLE=0, RUN=1, FLUSH=2, DONE=3)
// -----------------------------------------------------------------------------
module blur_mem_arbiter #(
    parameter int ROWS = 480,
    parameter int LAG  = 3,
    parameter int AW   = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    blur_mem_arbiter_if.slave   bus,
    output logic [AW:0]         wr_count,
    output logic [AW:0]         rd_count,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [AW:0]   ROWS_C = (AW+1)'(ROWS);
    // Distance a read must trail the writer: the row itself plus LAG below it.
    localparam logic [AW+1:0] NEED_C = (AW+2)'(LAG + 1);
    localparam logic [AW:0]   ONE_C  = (AW+1)'(1);

    state_e        state_q, state_d;
    logic [AW:0]   wr_count_q, wr_count_d;
    logic [AW:0]   rd_count_q, rd_count_d;
    logic          err_q, err_d;
    // rr_q = 1: Gaussian was granted most recently, so detect wins a tie.
    logic          rr_q, rr_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;

    logic          gauss_elig;
    logic          det_elig;
    logic          gauss_grant;
    logic          det_grant;
    logic [AW+1:0] det_need;

    // Eligibility. wr_count >= min(need, ROWS) is evaluated as
    // (wr_count >= need) || (wr_count >= ROWS) to avoid a clipped temporary.
    always_comb begin
        det_need   = {2'b00, bus.det_row} + NEED_C;
        gauss_elig = bus.gauss_req && (wr_count_q < ROWS_C);
        det_elig   = bus.det_req && (rd_count_q < ROWS_C) &&
                     (({1'b0, wr_count_q} >= det_need) || (wr_count_q >= ROWS_C));
    end

    // Next-state, grant and command logic.
    always_comb begin
        state_d     = state_q;
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        err_d       = err_q;
        rr_d        = rr_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        gauss_grant = 1'b0;
        det_grant   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    wr_count_d = '0;
                    rd_count_d = '0;
                    err_d      = 1'b0;
                    rr_d       = 1'b0;
                end
            end

            ST_RUN: begin
                if (gauss_elig && det_elig) begin
                    gauss_grant = !rr_q;
                    det_grant   = rr_q;
                end else begin
                    gauss_grant = gauss_elig;
                    det_grant   = det_elig;
                end

                if (gauss_grant) begin
                    rr_d = 1'b1;
                    // An out-of-order write is acknowledged so the writer is
                    // not stalled, but nothing reaches memory.
                    if ({1'b0, bus.gauss_row} == wr_count_q) begin
                        mem_en_d   = 1'b1;
                        mem_we_d   = 1'b1;
                        mem_addr_d = bus.gauss_row;
                        wr_count_d = wr_count_q + ONE_C;
                    end else begin
                        err_d = 1'b1;
                    end
                end

                if (det_grant) begin
                    rr_d       = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.det_row;
                    rd_count_d = rd_count_q + ONE_C;
                    // The final read command is still presented during FLUSH.
                    if (rd_count_d == ROWS_C) begin
                        state_d = ST_FLUSH;
                    end
                end
            end

            ST_FLUSH: begin
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_count_q <= '0;
            rd_count_q <= '0;
            err_q      <= 1'b0;
            rr_q       <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            err_q      <= err_d;
            rr_q       <= rr_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.gauss_ack = gauss_grant;
    assign bus.det_ack   = det_grant;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;

    assign wr_count  = wr_count_q;
    assign rd_count  = rd_count_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_blur_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_blur_mem_arbiter
//
// Bench for blur_mem_arbiter with ROWS=8, LAG=3, AW=9. Inputs change on the
// falling edge; acks are sampled 1 time unit later; registered outputs are
// sampled on the falling edge. Every granted in-order write and every granted
// read pushes its expected memory command; the monitor pops and compares
// whenever mem_en is seen high.
// -----------------------------------------------------------------------------
module tb_blur_mem_arbiter;
    localparam int ROWS = 8;
    localparam int LAG  = 3;
    localparam int AW   = 9;

    // clock/reset
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic [AW:0] wr_count;
    logic [AW:0] rd_count;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  state_dbg;

    blur_mem_arbiter_if #(.AW(AW)) bus ();

    blur_mem_arbiter #(
        .ROWS(ROWS),
        .LAG (LAG),
        .AW  (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .wr_count (wr_count),
        .rd_count (rd_count),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .state_dbg(state_dbg)
    );

    // scoreboard state
    int          n_total = 0;
    int          n_bad   = 0;
    string       phase   = "init";
    logic [AW:0] exp_q[$];     // {we, addr}
    int          exp_wr  = 0;
    int          exp_rd  = 0;
    logic        exp_err = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s/%s got=%0d exp=%0d t=%0t", phase, tag, got, exp, $time);
        end
    endtask

    // memory command monitor
    always @(negedge clk) begin
        if (rst_n && bus.mem_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("mem_unexpected", 32'd1, 32'd0);
            end else begin
                logic [AW:0] e;
                e = exp_q.pop_front();
                check_eq("mem_cmd", {bus.mem_we, bus.mem_addr}, e);
            end
        end
    end

    // driver: one cycle of requests with the expected acks
    task automatic cyc(input logic gr, input int grow, input logic dr, input int drow,
                       input logic eg, input logic ed);
        @(negedge clk);
        check_eq("wr_count", wr_count, exp_wr);
        check_eq("rd_count", rd_count, exp_rd);
        check_eq("err", err, exp_err);
        bus.gauss_req = gr;
        bus.gauss_row = AW'(grow);
        bus.det_req   = dr;
        bus.det_row   = AW'(drow);
        #1;
        check_eq("gauss_ack", bus.gauss_ack, eg);
        check_eq("det_ack", bus.det_ack, ed);
        if (eg) begin
            if (grow == exp_wr) begin
                exp_q.push_back({1'b1, AW'(grow)});
                exp_wr++;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (ed) begin
            exp_q.push_back({1'b0, AW'(drow)});
            exp_rd++;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.gauss_req = 1'b0;
        bus.det_req   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        exp_wr  = 0;
        exp_rd  = 0;
        exp_err = 1'b0;
    endtask

    // Reset is asserted away from any clock edge and checked before the next one.
    task automatic async_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_state", state_dbg, 0);
        check_eq("rst_wr", wr_count, 0);
        check_eq("rst_rd", rd_count, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_mem_en", bus.mem_en, 0);
        check_eq("rst_mem_we", bus.mem_we, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_gack", bus.gauss_ack, 0);
        check_eq("rst_dack", bus.det_ack, 0);
        exp_q.delete();
        exp_wr  = 0;
        exp_rd  = 0;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.gauss_req = 1'b0;
        bus.gauss_row = '0;
        bus.det_req   = 1'b0;
        bus.det_row   = '0;

        // reset and idle: requests without start are ignored
        phase = "idle";
        async_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_mem_en", bus.mem_en, 0);
        end

        // frame A: lag gating, round robin, full frame
        phase = "lag";
        do_start();
        cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        check_eq("run_busy", busy, 1);
        for (int r = 0; r < 4; r++) begin
            cyc(1'b1, r, 1'b1, 0, 1'b1, 1'b0);
        end
        phase = "rr";
        cyc(1'b1, 4, 1'b1, 0, 1'b0, 1'b1);   // wr_count=4: first read, detect wins tie
        cyc(1'b1, 4, 1'b1, 0, 1'b1, 1'b0);
        cyc(1'b1, 5, 1'b1, 1, 1'b0, 1'b1);
        cyc(1'b1, 5, 1'b1, 1, 1'b1, 1'b0);
        cyc(1'b1, 6, 1'b1, 2, 1'b0, 1'b1);
        cyc(1'b1, 6, 1'b1, 2, 1'b1, 1'b0);
        cyc(1'b1, 7, 1'b1, 3, 1'b0, 1'b1);
        cyc(1'b1, 7, 1'b1, 3, 1'b1, 1'b0);
        phase = "frame";
        cyc(1'b1, 0, 1'b1, 4, 1'b0, 1'b1);   // writer saturated at ROWS
        cyc(1'b0, 0, 1'b1, 5, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b1, 6, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b1, 7, 1'b0, 1'b1);   // 8th read
        cyc(1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
        check_eq("flush_state", state_dbg, 2);
        check_eq("flush_busy", busy, 1);
        check_eq("flush_done", done, 0);
        cyc(1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
        check_eq("done_state", state_dbg, 3);
        check_eq("done_level", done, 1);
        check_eq("done_busy", busy, 0);
        cyc(1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
        check_eq("done_hold", done, 1);

        // frame B: restart clears counts, bottom-edge read
        phase = "bottom";
        do_start();
        cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        check_eq("restart_done", done, 0);
        for (int r = 0; r < 7; r++) begin
            cyc(1'b1, r, 1'b0, 0, 1'b1, 1'b0);
        end
        cyc(1'b1, 7, 1'b1, 6, 1'b1, 1'b0);   // wr_count=7: row 6 not yet readable
        cyc(1'b0, 0, 1'b1, 6, 1'b0, 1'b1);   // wr_count=8: granted
        phase = "start_in_run";
        @(negedge clk);
        bus.gauss_req = 1'b0;
        bus.det_req   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("ign_wr", wr_count, 8);
        check_eq("ign_rd", rd_count, 1);
        check_eq("ign_state", state_dbg, 1);
        check_eq("sb_drain_b", exp_q.size(), 0);
        async_reset();

        // frame C: out-of-order write, then mid-frame reset
        phase = "error";
        do_start();
        cyc(1'b1, 0, 1'b0, 0, 1'b1, 1'b0);
        cyc(1'b1, 1, 1'b0, 0, 1'b1, 1'b0);
        cyc(1'b1, 5, 1'b0, 0, 1'b1, 1'b0);   // wr_count=2, row 5 out of order
        cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        check_eq("err_mem_en", bus.mem_en, 0);
        check_eq("hold_mem_we", bus.mem_we, 1);
        check_eq("hold_mem_addr", bus.mem_addr, 1);
        check_eq("err_busy", busy, 1);
        check_eq("sb_drain_c", exp_q.size(), 0);
        phase = "mid_reset";
        async_reset();
        cyc(1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
        check_eq("post_rst_busy", busy, 0);

        repeat (2) @(negedge clk);
        phase = "end";
        check_eq("sb_final", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
